cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
- Instruction fetch and sequencing stage of the MIPS processor: holds the PC, fetches 16-bit instructions from instruction memory, and splits them into fields.
- Drives cpu_opcode into the control unit and consumes that unit's cpu_jump/cpu_branch decisions, plus the ALU zero flag, to select the next PC.
- Also supplies pc_plus2, the return address used by jal.

Parameters:
- PC_WIDTH, 16, program counter width in bits; must be >= 14.
- RESET_PC, 0, PC value loaded on reset; must be even.
- FETCH_TIMEOUT, 15, cycles without imem_valid before a fetch error (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction memory request.
- imem_addr  output  PC_WIDTH  fetch address; equals the current PC.
- imem_rdata  input  16  instruction word.
- imem_valid  input  1  imem_rdata valid; sampled only while imem_req=1.
- cpu_jump  input  1  jump decision from the control unit.
- cpu_branch  input  1  branch decision from the control unit.
- alu_zero  input  1  ALU zero flag for beq.
- cpu_stall  input  1  hold the current instruction.
- cpu_opcode  output  3  instruction bits [15:13].
- instr_rs  output  3  bits [12:10].
- instr_rt  output  3  bits [9:7].
- instr_rd  output  3  bits [6:4].
- instr_imm  output  7  bits [6:0].
- jump_target  output  13  bits [12:0].
- instr_valid  output  1  the instruction register holds the instruction being issued.
- pc_plus2  output  PC_WIDTH  PC+2 of the issued instruction, modulo 2^PC_WIDTH.
- fetch_err  output  1  one-cycle pulse on fetch timeout (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, immediate):
  - PC=RESET_PC; state=IDLE; instruction register=0.
  - imem_req=0, instr_valid=0, fetch_err=0.
  - All field outputs reflect instruction register 0, so cpu_opcode=000.
- State machine:
  - IDLE: go to FETCH on the first clock edge after reset is released.
  - FETCH: imem_req=1 and imem_addr=PC. On an edge where imem_valid=1, load imem_rdata into the instruction register, go to ISSUE, clear imem_req. Zero-wait memory may return imem_valid in the same cycle as the request.
  - ISSUE: instr_valid=1. Field outputs are combinational slices of the instruction register. pc_plus2=PC+2.
    - cpu_stall=1: remain in ISSUE; PC and all outputs are unchanged.
    - cpu_stall=0: PC<=next_pc, go to FETCH, instr_valid falls on the next cycle.
- Throughput: minimum 2 cycles per instruction (FETCH, ISSUE).
- next_pc, evaluated in ISSUE, in priority order:
  - cpu_jump=1: {pc_plus2[PC_WIDTH-1:14], jump_target, 1'b0}.
  - cpu_branch=1 and alu_zero=1: pc_plus2 + (sign-extended instr_imm << 1).
  - Otherwise: pc_plus2.
- Arithmetic wraps modulo 2^PC_WIDTH. PC bit 0 is always 0.
- cpu_jump and cpu_branch both high: jump wins.
- cpu_branch=1 with alu_zero=0: sequential fetch (pc_plus2).
- imem_valid outside FETCH: ignored, no state change.
- cpu_jump, cpu_branch, alu_zero outside ISSUE: ignored.
- Reset asserted mid-FETCH: imem_req drops immediately. A late imem_valid after reset is released is ignored because the block is in IDLE, then re-fetches from RESET_PC.
- Reset asserted mid-ISSUE: the instruction is discarded and instr_valid drops immediately.

Optional Feature:
- Macro: CPU_FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entering FETCH and increments each FETCH cycle with imem_valid=0.
  - When the count reaches FETCH_TIMEOUT, fetch_err pulses high for one cycle, the counter clears, and the request restarts at the same PC. imem_req drops to 0 for that single cycle.
  - The counter resets to 0.
- Undefined: no counter is built; fetch_err is tied to 0 and FETCH waits indefinitely.

Test Plan:
- Sequential: RESET_PC=0, zero-wait memory returns 0x0000 (add) at every address, no stall -> imem_addr sequence 0x0000, 0x0002, 0x0004; instr_valid high every other cycle; pc_plus2=0x0002 during the first ISSUE.
- Jump: instruction 0x4005 at 0x0010, cpu_jump=1 -> next imem_addr=0x000A; cpu_opcode=010 during ISSUE.
- Branch: beq at 0x0020 with imm=0x7E (-2), cpu_branch=1:
  - alu_zero=1 -> next imem_addr=0x001E.
  - alu_zero=0 -> next imem_addr=0x0022.
- Stall and priority:
  - cpu_stall=1 for 3 ISSUE cycles -> instr_valid and fields hold, PC unchanged, imem_req=0; release -> fetch from PC+2.
  - cpu_jump=1 and cpu_branch=1 together -> the jump target is taken.
- Reset mid-fetch: drive rst_n=0 while imem_req=1 at 0x0008, pulse imem_valid after release -> imem_req=0 during reset, stale data is ignored, the next fetch is at 0x0000.
- Timeout (CPU_FETCH_TIMEOUT_EN, FETCH_TIMEOUT=15): hold imem_valid=0 -> fetch_err pulses in the cycle when the count reaches 15, imem_req=0 for that cycle, then the request re-issues at the same address; without the macro, fetch_err stays 0.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch/sequencing stage: PC, 16-bit instruction register, field split and next-PC select.
// Optional fetch timeout with retry is built when CPU_FETCH_TIMEOUT_EN is defined.
module cpu_fetch_unit #(
  parameter int unsigned PC_WIDTH      = 16,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic                cpu_jump,
  input  logic                cpu_branch,
  input  logic                alu_zero,
  input  logic                cpu_stall,
  output logic [2:0]          cpu_opcode,
  output logic [2:0]          instr_rs,
  output logic [2:0]          instr_rt,
  output logic [2:0]          instr_rd,
  output logic [6:0]          instr_imm,
  output logic [12:0]         jump_target,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_plus2,
  output logic                fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_RETRY} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_seq, jump_pc, branch_pc, imm_ext, next_pc;
  logic                timeout;

  if (PC_WIDTH < 14 || FETCH_TIMEOUT < 1 || (RESET_PC % 2) != 0) begin : g_param_check
    $error("cpu_fetch_unit: illegal parameter combination");
  end

  assign pc_seq  = pc_q + PC_WIDTH'(2);
  assign imm_ext = {{(PC_WIDTH-7){ir_q[6]}}, ir_q[6:0]};
  assign branch_pc = pc_seq + (imm_ext << 1);

  // Jump keeps the upper PC bits of the sequential address above the 14-bit target window.
  if (PC_WIDTH > 14) begin : g_jump_wide
    assign jump_pc = {pc_seq[PC_WIDTH-1:14], ir_q[12:0], 1'b0};
  end else begin : g_jump_narrow
    assign jump_pc = {ir_q[12:0], 1'b0};
  end

  always_comb begin
    if (cpu_jump)                    next_pc = jump_pc;
    else if (cpu_branch && alu_zero) next_pc = branch_pc;
    else                             next_pc = pc_seq;
  end

`ifdef CPU_FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == S_FETCH && !imem_valid) begin
      if (cnt_q == CW'(FETCH_TIMEOUT - 1)) timeout = 1'b1;
      else                                 cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fetch_err = (state_q == S_RETRY);
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end else if (timeout) begin
          state_d = S_RETRY;
        end
      end
      S_ISSUE: begin
        if (!cpu_stall) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_RETRY: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_WIDTH'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[PC_WIDTH-1:1], 1'b0};
      ir_q    <= ir_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign pc_plus2    = pc_seq;
  assign cpu_opcode  = ir_q[15:13];
  assign instr_rs    = ir_q[12:10];
  assign instr_rt    = ir_q[9:7];
  assign instr_rd    = ir_q[6:4];
  assign instr_imm   = ir_q[6:0];
  assign jump_target = ir_q[12:0];

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed self-checking bench for cpu_fetch_unit (default parameters).
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        cpu_jump, cpu_branch, alu_zero, cpu_stall;
  logic [2:0]  cpu_opcode, instr_rs, instr_rt, instr_rd;
  logic [6:0]  instr_imm;
  logic [12:0] jump_target;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  cpu_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .cpu_jump(cpu_jump), .cpu_branch(cpu_branch), .alu_zero(alu_zero), .cpu_stall(cpu_stall),
    .cpu_opcode(cpu_opcode), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .instr_imm(instr_imm), .jump_target(jump_target), .instr_valid(instr_valid),
    .pc_plus2(pc_plus2), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
    cpu_jump = 1'b0; cpu_branch = 1'b0; alu_zero = 1'b0; cpu_stall = 1'b0;
    repeat (2) tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", cpu_opcode, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_err", fetch_err, 0);

    // Sequential: zero-wait memory returning 0x0000
    rst_n = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h0000;
    tick();
    check("seq_req0", imem_req, 1);
    check("seq_addr0", imem_addr, 16'h0000);
    tick();
    check("seq_iv0", instr_valid, 1);
    check("seq_pcp2", pc_plus2, 16'h0002);
    check("seq_req_issue", imem_req, 0);
    tick();
    check("seq_iv_fetch", instr_valid, 0);
    check("seq_addr1", imem_addr, 16'h0002);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("seq_iv_k", instr_valid, 1);
      tick();
      check("seq_addr_k", imem_addr, 32'(2 * k));
    end

    // Jump: 0x4005 at 0x0010 -> 0x000A
    imem_rdata = 16'h4005;
    tick();
    check("jmp_opcode", cpu_opcode, 3'b010);
    check("jmp_target", jump_target, 13'h0005);
    cpu_jump = 1'b1;
    tick();
    check("jmp_addr", imem_addr, 16'h000A);
    // jump 0x4010 -> 0x0020
    imem_rdata = 16'h4010;
    tick();
    tick();
    check("jmp2_addr", imem_addr, 16'h0020);
    cpu_jump = 1'b0;

    // Branch taken: beq imm=-2 at 0x0020 -> 0x001E
    imem_rdata = 16'h807E;
    tick();
    check("br_imm", instr_imm, 7'h7E);
    cpu_branch = 1'b1; alu_zero = 1'b1;
    tick();
    check("br_taken_addr", imem_addr, 16'h001E);
    // Jump and branch together at 0x001E: jump to 0x0020 wins over branch to 0x0040
    imem_rdata = 16'h4010;
    tick();
    cpu_jump = 1'b1;
    tick();
    check("prio_addr", imem_addr, 16'h0020);
    cpu_jump = 1'b0;
    // Branch not taken
    imem_rdata = 16'h807E;
    tick();
    alu_zero = 1'b0;
    tick();
    check("br_nt_addr", imem_addr, 16'h0022);
    cpu_branch = 1'b0;

    // Stall for 3 ISSUE cycles at 0x0022 with 0xB5A7
    imem_rdata = 16'hB5A7;
    tick();
    cpu_stall = 1'b1; imem_rdata = 16'h0000;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_iv", instr_valid, 1);
      check("stall_req", imem_req, 0);
      check("stall_addr", imem_addr, 16'h0022);
      check("stall_opcode", cpu_opcode, 3'b101);
      check("stall_rs", instr_rs, 3'd5);
      check("stall_rt", instr_rt, 3'd3);
      check("stall_rd", instr_rd, 3'd2);
      check("stall_imm", instr_imm, 7'h27);
      check("stall_jt", jump_target, 13'h15A7);
    end
    cpu_stall = 1'b0;
    tick();
    check("unstall_addr", imem_addr, 16'h0024);
    check("unstall_iv", instr_valid, 0);

    // Reset mid-fetch at 0x0008
    imem_rdata = 16'h4004;
    tick();
    cpu_jump = 1'b1;
    tick();
    cpu_jump = 1'b0; imem_valid = 1'b0;
    check("mf_addr", imem_addr, 16'h0008);
    tick();
    check("mf_req_pre", imem_req, 1);
    rst_n = 1'b0;
    #1;
    check("mf_req_rst", imem_req, 0);
    check("mf_addr_rst", imem_addr, 16'h0000);
    tick();
    rst_n = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h4005;
    tick();
    check("mf_stale_iv", instr_valid, 0);
    check("mf_refetch_req", imem_req, 1);
    check("mf_refetch_addr", imem_addr, 16'h0000);
    imem_rdata = 16'h2000;
    tick();
    check("mf_new_opcode", cpu_opcode, 3'b001);

    // Reset mid-issue
    rst_n = 1'b0;
    #1;
    check("mi_iv", instr_valid, 0);
    check("mi_opcode", cpu_opcode, 0);
    tick();
    rst_n = 1'b1; imem_valid = 1'b0;
    tick();

`ifdef CPU_FETCH_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      check("to_wait_req", imem_req, 1);
      check("to_wait_err", fetch_err, 0);
      tick();
    end
    check("to_err", fetch_err, 1);
    check("to_req_drop", imem_req, 0);
    tick();
    check("to_retry_req", imem_req, 1);
    check("to_retry_err", fetch_err, 0);
    check("to_retry_addr", imem_addr, 16'h0000);
`else
    for (int c = 0; c < 20; c++) begin
      check("nto_req", imem_req, 1);
      check("nto_err", fetch_err, 0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
